// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : gshare direction predictor (2-bit PHT) plus direct-mapped BTB,
//            zero-latency lookup, non-speculative history updated from execute.
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int DBITS    = 32,
    parameter int GHR_BITS = 8,
    parameter int BTB_IDX  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    fe_pc,
    output logic                pred_taken,
    output logic [DBITS-1:0]    pred_pc_next,
    output logic [GHR_BITS-1:0] pred_index,
    input  logic                upd_valid,
    input  logic [DBITS-1:0]    upd_pc,
    input  logic                upd_taken,
    input  logic [DBITS-1:0]    upd_target,
    input  logic [GHR_BITS-1:0] upd_index,
    input  logic                upd_pred_taken,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int c_PHT_DEPTH = 1 << GHR_BITS;
    localparam int c_BTB_DEPTH = 1 << BTB_IDX;
    localparam int c_TAG_W     = DBITS - BTB_IDX - 2;
    localparam logic [DBITS-1:0] c_PC_STEP = DBITS'(4);

    logic [1:0]             r_pht       [c_PHT_DEPTH];
    logic [c_BTB_DEPTH-1:0] r_btb_valid;
    logic [c_TAG_W-1:0]     r_btb_tag   [c_BTB_DEPTH];
    logic [DBITS-1:0]       r_btb_tgt   [c_BTB_DEPTH];
    logic [GHR_BITS-1:0]    r_ghr;
    logic [31:0]            r_stat_branches;
    logic [31:0]            r_stat_mispredicts;

    logic [GHR_BITS-1:0]    w_pred_index;
    logic [BTB_IDX-1:0]     w_fe_slot;
    logic [c_TAG_W-1:0]     w_fe_tag;
    logic                   w_btb_hit;
    logic                   w_pred_taken;
    logic [BTB_IDX-1:0]     w_upd_slot;
    logic [c_TAG_W-1:0]     w_upd_tag;
    logic [1:0]             w_upd_cnt;

    // Lookup path: purely combinational off current state, no update bypass.
    assign w_pred_index = fe_pc[GHR_BITS+1:2] ^ r_ghr;
    assign w_fe_slot    = fe_pc[BTB_IDX+1:2];
    assign w_fe_tag     = fe_pc[DBITS-1:BTB_IDX+2];
    assign w_btb_hit    = r_btb_valid[w_fe_slot] && (r_btb_tag[w_fe_slot] == w_fe_tag);
    assign w_pred_taken = r_pht[w_pred_index][1] && w_btb_hit;

    assign pred_taken       = w_pred_taken;
    assign pred_index       = w_pred_index;
    assign pred_pc_next     = w_pred_taken ? r_btb_tgt[w_fe_slot] : (fe_pc + c_PC_STEP);
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

    assign w_upd_slot = upd_pc[BTB_IDX+1:2];
    assign w_upd_tag  = upd_pc[DBITS-1:BTB_IDX+2];
    assign w_upd_cnt  = r_pht[upd_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_PHT_DEPTH; i++) begin
                r_pht[i] <= 2'b01;
            end
            r_btb_valid        <= '0;
            r_ghr              <= '0;
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (w_upd_cnt != 2'b11) begin
                    r_pht[upd_index] <= w_upd_cnt + 2'b01;
                end
                r_btb_valid[w_upd_slot] <= 1'b1;
            end else if (w_upd_cnt != 2'b00) begin
                r_pht[upd_index] <= w_upd_cnt - 2'b01;
            end
            r_ghr           <= {r_ghr[GHR_BITS-2:0], upd_taken};
            r_stat_branches <= r_stat_branches + 32'd1;
            if (upd_pred_taken != upd_taken) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    // Tag/target payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            r_btb_tag[w_upd_slot] <= w_upd_tag;
            r_btb_tgt[w_upd_slot] <= upd_target;
        end
    end

endmodule
`default_nettype wire
